// File: rtl/uint_to_float_pipe_if.sv
// rtl/uint_to_float_pipe_if.sv - operand/result valid-ready bundle for uint_to_float_pipe
interface uint_to_float_pipe_if #(
    parameter int IN_W = 8
) ();
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     out_data;
    logic            out_inexact;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_inexact, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_inexact, out_valid
    );
endinterface

// File: rtl/uint_to_float_pipe.sv
// rtl/uint_to_float_pipe.sv - 3-stage unsigned fixed-point to IEEE-754 single converter
// Define UINT2FLT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module uint_to_float_pipe #(
    parameter int IN_W      = 8,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    uint_to_float_pipe_if.slave bus
);

    if (IN_W < 1 || IN_W > 32) begin : g_bad_in_w
        $error("uint_to_float_pipe: IN_W must be in 1..32");
    end
    if (FRAC_BITS > 126 || (IN_W - 1 - FRAC_BITS) > 127) begin : g_bad_frac
        $error("uint_to_float_pipe: FRAC_BITS puts results outside the normal range");
    end

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic [4:0]  s2_msb_q, s2_msb_d;
    logic        s3_valid_q, s3_valid_d;
    logic [31:0] s3_data_q, s3_data_d;
    logic        s3_inexact_q, s3_inexact_d;

    logic        s1_load, s2_load, s3_load;
    logic [4:0]  msb_idx;
    logic [30:0] norm;
    logic [22:0] mant;
    logic        guard, sticky;
    logic [7:0]  exp_f;
    logic [30:0] packed_mag;

    // A stage may load when it is empty or its contents move on this edge.
    always_comb begin
        s3_load = !s3_valid_q || bus.out_ready;
        s2_load = !s2_valid_q || s3_load;
        s1_load = !s1_valid_q || s2_load;
    end

    assign bus.in_ready    = s1_load;
    assign bus.out_valid   = s3_valid_q;
    assign bus.out_data    = s3_data_q;
    assign bus.out_inexact = s3_inexact_q;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (s1_data_q[i]) begin
                msb_idx = 5'(i);
            end
        end
    end

    // Shifting the MSB to bit 31 and dropping it leaves mantissa, guard and sticky in fixed places.
    always_comb begin
        norm       = 31'(s2_data_q << (5'd31 - s2_msb_q));
        mant       = norm[30:8];
        guard      = norm[7];
        sticky     = |norm[6:0];
        exp_f      = 8'd127 + 8'(s2_msb_q) - 8'(FRAC_BITS);
`ifdef UINT2FLT_RNE_EN
        packed_mag = {exp_f, mant} + 31'(guard && (sticky || mant[0]));
`else
        packed_mag = {exp_f, mant};
`endif
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_msb_d     = s2_msb_q;
        s3_valid_d   = s3_valid_q;
        s3_data_d    = s3_data_q;
        s3_inexact_d = s3_inexact_q;

        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = 32'(bus.in_data);
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
                s2_msb_d  = msb_idx;
            end
        end

        // Output registers only change on a real load so they hold steady under backpressure.
        if (s3_load) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                if (s2_data_q == 32'd0) begin
                    s3_data_d    = 32'd0;
                    s3_inexact_d = 1'b0;
                end else begin
                    s3_data_d    = {1'b0, packed_mag};
                    s3_inexact_d = guard || sticky;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_msb_q     <= '0;
            s3_valid_q   <= 1'b0;
            s3_data_q    <= '0;
            s3_inexact_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_msb_q     <= s2_msb_d;
            s3_valid_q   <= s3_valid_d;
            s3_data_q    <= s3_data_d;
            s3_inexact_q <= s3_inexact_d;
        end
    end

endmodule
